dram_cmd_gen: RTL and testbench

DRAM_CMD_GEN -- requirements
Module: dram_cmd_gen

---
 rtl/global_defs.sv | 84 ++++++++
 rtl/bank_tracker.sv | 50 +++++
 rtl/dram_cmd_gen.sv | 174 +++++++++++++++++
 tb/tb_dram_cmd_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/global_defs.sv
// Shared types, timing defaults and address map for dram_cmd_gen.
// Build macro OPEN_PAGE_EN keeps rows open; without it RD/WR auto-precharge.
package global_defs;

    localparam int T_RCD_DEF   = 24;
    localparam int T_RP_DEF    = 24;
    localparam int T_RAS_DEF   = 52;
    localparam int T_CL_DEF    = 24;
    localparam int T_CWL_DEF   = 20;
    localparam int T_BURST_DEF = 4;

    localparam int ADDR_W = 33;
    localparam int BG_W   = 2;
    localparam int BANK_W = 2;
    localparam int ROW_W  = 15;
    localparam int COL_W  = 8;
    localparam int IDX_W  = BG_W + BANK_W;
    localparam int NBANKS = 1 << IDX_W;

    localparam int COL_OFF  = 3;
    localparam int BANK_OFF = 11;
    localparam int BG_OFF   = 13;
    localparam int ROW_OFF  = 15;

    localparam logic [ADDR_W-1:0] COL_MASK  = ADDR_W'({COL_W{1'b1}}) << COL_OFF;
    localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'({BANK_W{1'b1}}) << BANK_OFF;
    localparam logic [ADDR_W-1:0] BG_MASK   = ADDR_W'({BG_W{1'b1}}) << BG_OFF;
    localparam logic [ADDR_W-1:0] ROW_MASK  = ADDR_W'({ROW_W{1'b1}}) << ROW_OFF;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2
    } opcode_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } dram_cmd_t;

`ifdef OPEN_PAGE_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ACT, S_RW, S_DATA
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ACT, S_RW, S_DATA, S_AP_WAIT
    } state_t;
`endif

    typedef struct packed {
        opcode_t             opcode;
        logic [ADDR_W-1:0]   addr;
    } queue_output_t;

    typedef struct packed {
        logic                open;
        logic [ROW_W-1:0]    row;
    } bank_entry_t;

    typedef struct packed {
        logic [BG_W-1:0]     bg;
        logic [BANK_W-1:0]   bank;
        logic [ROW_W-1:0]    row;
        logic [COL_W-1:0]    col;
    } addr_fields_t;

    function automatic addr_fields_t decode(input logic [ADDR_W-1:0] a);
        addr_fields_t f;
        f.bg   = BG_W'((a & BG_MASK) >> BG_OFF);
        f.bank = BANK_W'((a & BANK_MASK) >> BANK_OFF);
        f.row  = ROW_W'((a & ROW_MASK) >> ROW_OFF);
        f.col  = COL_W'((a & COL_MASK) >> COL_OFF);
        return f;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bank_tracker.sv
// Per-bank open/row table and tRAS countdown used by dram_cmd_gen.
// ACT opens a bank and restarts its tRAS timer; close_en marks it closed.
module bank_tracker
    import global_defs::*;
#(
    parameter int T_RAS = T_RAS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [ROW_W-1:0] lk_row,
    output logic             hit,
    output logic             miss,
    output logic             tras_done,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [ROW_W-1:0] upd_row,
    input  logic             act_en,
    input  logic             close_en
);

    localparam int TW = (T_RAS > 2) ? $clog2(T_RAS) : 1;

    bank_entry_t   tbl  [NBANKS];
    logic [TW-1:0] tras [NBANKS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBANKS; i++) begin
                tbl[i]  <= '0;
                tras[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBANKS; i++) begin
                if (act_en && upd_idx == IDX_W'(i))
                    tras[i] <= TW'(T_RAS - 1);
                else if (tras[i] != '0)
                    tras[i] <= tras[i] - 1'b1;
            end
            if (act_en)
                tbl[upd_idx] <= {1'b1, upd_row};
            else if (close_en)
                tbl[upd_idx].open <= 1'b0;
        end
    end

    assign hit       = tbl[lk_idx].open && (tbl[lk_idx].row == lk_row);
    assign miss      = tbl[lk_idx].open && (tbl[lk_idx].row != lk_row);
    assign tras_done = (tras[lk_idx] == '0);

endmodule

// File: rtl/dram_cmd_gen.sv
// Single-request DRAM command sequencer: PRE/ACT/RD/WR with fixed spacing.
// OPEN_PAGE_EN selects open-page policy; default issues RD/WR with auto-precharge.
module dram_cmd_gen
    import global_defs::*;
#(
    parameter int T_RCD   = T_RCD_DEF,
    parameter int T_RP    = T_RP_DEF,
    parameter int T_RAS   = T_RAS_DEF,
    parameter int T_CL    = T_CL_DEF,
    parameter int T_CWL   = T_CWL_DEF,
    parameter int T_BURST = T_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  queue_output_t     req,
    output logic              req_ready,
    output logic              cmd_valid,
    output dram_cmd_t         cmd,
    output logic [BG_W-1:0]   cmd_bg,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              cmd_ap,
    output logic              rsp_valid,
    output logic [1:0]        rsp_opcode
);

    localparam int MAX_LD =
        max2(max2(T_RCD, T_RP), max2(T_CL, T_CWL) + T_BURST) - 1;
    localparam int CW = $clog2(MAX_LD + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    data_ld;
    opcode_t          op_q;
    addr_fields_t     fq;
    addr_fields_t     fr;
    logic             accept;
    logic             hit;
    logic             miss;
    logic             tras_done;
    logic             pre_go;
    logic             act_go;
    logic             rw_go;
    logic             close_en;
    logic             ap_bit;
    logic [IDX_W-1:0] lk_idx;
    logic [ROW_W-1:0] lk_row;

    assign fr     = decode(req.addr);
    assign accept = req_valid && req_ready;

    // In IDLE the table is probed with the incoming request, else the latched one.
    assign lk_idx = (state == S_IDLE) ? {fr.bg, fr.bank} : {fq.bg, fq.bank};
    assign lk_row = (state == S_IDLE) ? fr.row : fq.row;

    assign pre_go = (state == S_PRE) && tras_done;
    assign act_go = (state == S_ACT) && (cnt == '0);
    assign rw_go  = (state == S_RW) && (cnt == '0);

    assign data_ld = (op_q == OP_WRITE) ? CW'(T_CWL + T_BURST - 1)
                                        : CW'(T_CL + T_BURST - 1);

`ifdef OPEN_PAGE_EN
    assign close_en = pre_go;
    assign ap_bit   = 1'b0;
`else
    assign close_en = rw_go;
    assign ap_bit   = 1'b1;
    logic unused_lk;
    assign unused_lk = ^{hit, miss};
`endif

    bank_tracker #(
        .T_RAS(T_RAS)
    ) u_banks (
        .clk      (clk),
        .rst_n    (rst_n),
        .lk_idx   (lk_idx),
        .lk_row   (lk_row),
        .hit      (hit),
        .miss     (miss),
        .tras_done(tras_done),
        .upd_idx  ({fq.bg, fq.bank}),
        .upd_row  (fq.row),
        .act_en   (act_go),
        .close_en (close_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= OP_READ;
            fq         <= '0;
            req_ready  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= CMD_NOP;
            cmd_bg     <= '0;
            cmd_bank   <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            cmd_ap     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_opcode <= '0;
        end else begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_ap    <= 1'b0;
            rsp_valid <= 1'b0;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (pre_go || act_go || rw_go) begin
                cmd_valid <= 1'b1;
                cmd_bg    <= fq.bg;
                cmd_bank  <= fq.bank;
                cmd_row   <= fq.row;
                cmd_col   <= fq.col;
            end
            unique case (state)
                S_IDLE: begin
                    req_ready <= !accept;
                    if (accept) begin
                        op_q <= req.opcode;
                        fq   <= fr;
                        cnt  <= '0;
`ifdef OPEN_PAGE_EN
                        state <= hit  ? S_RW :
                                 miss ? S_PRE : S_ACT;
`else
                        state <= S_ACT;
`endif
                    end
                end
                S_PRE: if (pre_go) begin
                    cmd   <= CMD_PRE;
                    cnt   <= CW'(T_RP - 1);
                    state <= S_ACT;
                end
                S_ACT: if (act_go) begin
                    cmd   <= CMD_ACT;
                    cnt   <= CW'(T_RCD - 1);
                    state <= S_RW;
                end
                S_RW: if (rw_go) begin
                    cmd    <= (op_q == OP_WRITE) ? CMD_WR : CMD_RD;
                    cmd_ap <= ap_bit;
                    cnt    <= data_ld;
                    state  <= S_DATA;
                end
                S_DATA: if (cnt == '0) begin
                    rsp_valid  <= 1'b1;
                    rsp_opcode <= op_q;
`ifdef OPEN_PAGE_EN
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
`else
                    cnt        <= CW'(T_RP - 1);
                    state      <= S_AP_WAIT;
`endif
                end
`ifndef OPEN_PAGE_EN
                S_AP_WAIT: if (cnt == '0) begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_cmd_gen.sv
// Directed scoreboard bench for dram_cmd_gen (works with or without OPEN_PAGE_EN).
// Expected commands and responses are predicted at accept time and popped by a monitor.
module tb_dram_cmd_gen;
    import global_defs::*;

    localparam int T_RCD = 24, T_RP = 24, T_RAS = 80;
    localparam int T_CL = 24, T_CWL = 20, T_BURST = 4;
`ifdef OPEN_PAGE_EN
    localparam bit OPEN = 1'b1;
`else
    localparam bit OPEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    queue_output_t req = '0;
    logic          req_ready, cmd_valid, cmd_ap, rsp_valid;
    dram_cmd_t     cmd;
    logic [1:0]    cmd_bg, cmd_bank, rsp_opcode;
    logic [14:0]   cmd_row;
    logic [7:0]    cmd_col;

    dram_cmd_gen #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
        .T_CL(T_CL), .T_CWL(T_CWL), .T_BURST(T_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req(req), .req_ready(req_ready),
        .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap),
        .rsp_valid(rsp_valid), .rsp_opcode(rsp_opcode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        bit          rsp;
        dram_cmd_t   cmd;
        logic        ap;
        logic [1:0]  bg, bank;
        logic [14:0] row;
        logic [7:0]  col;
        logic [1:0]  op;
    } ev_t;

    ev_t  q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   m_open [16];
    logic [14:0] m_row [16];
    int   m_act [16];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                   tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [32:0] mk(input logic [1:0] bg,
        input logic [1:0] bank, input logic [14:0] row,
        input logic [7:0] col);
        return {3'b000, row, bg, bank, col, 3'b000};
    endfunction

    task automatic push(input int at, input bit rsp, input dram_cmd_t c,
                        input logic ap, input logic [32:0] a,
                        input opcode_t op);
        ev_t e;
        e.at = at; e.rsp = rsp; e.cmd = c; e.ap = ap;
        e.bg = a[14:13]; e.bank = a[12:11];
        e.row = a[29:15]; e.col = a[10:3]; e.op = op;
        q.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (rst_n && mon_en) begin
            if (q.size() != 0 && q[0].at < cyc) begin
                chk("missing_event", q[0].at, cyc);
                void'(q.pop_front());
            end
            if (cmd_valid || rsp_valid) begin
                if (q.size() == 0)
                    chk("unexpected_out", {cmd_valid, rsp_valid}, 2'b00);
                else if (q[0].at != cyc)
                    chk("early_out", cyc, q[0].at);
                else begin
                    e = q.pop_front();
                    if (e.rsp) begin
                        chk("rsp_valid", rsp_valid, 1'b1);
                        chk("rsp_opcode", rsp_opcode, e.op);
                        chk("rsp_no_cmd", cmd_valid, 1'b0);
                    end else begin
                        chk("cmd_valid", cmd_valid, 1'b1);
                        chk("cmd", cmd, e.cmd);
                        chk("cmd_ap", cmd_ap, e.ap);
                        chk("cmd_bg", cmd_bg, e.bg);
                        chk("cmd_bank", cmd_bank, e.bank);
                        if (e.cmd == CMD_ACT)
                            chk("cmd_row", cmd_row, e.row);
                        if (e.cmd == CMD_RD || e.cmd == CMD_WR)
                            chk("cmd_col", cmd_col, e.col);
                    end
                end
            end else
                chk("nop_idle", cmd, CMD_NOP);
        end
    end

    // Handshake plus prediction of every command and the response.
    task automatic accept(input opcode_t op, input logic [32:0] a,
                          output int t, output int rdy);
        int n = 0;
        int idx, pre_at, act_at, rw_at, rsp_at;
        logic [14:0] row;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", req_ready, 1'b1);
        req.opcode = op;
        req.addr   = a;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        t   = cyc;
        idx = int'({a[14:13], a[12:11]});
        row = a[29:15];
        if (OPEN && m_open[idx] && m_row[idx] == row)
            rw_at = t + 1;
        else begin
            act_at = t + 1;
            if (OPEN && m_open[idx]) begin
                pre_at = t + 1;
                if (m_act[idx] + T_RAS > pre_at)
                    pre_at = m_act[idx] + T_RAS;
                push(pre_at, 1'b0, CMD_PRE, 1'b0, a, op);
                act_at = pre_at + T_RP;
            end
            push(act_at, 1'b0, CMD_ACT, 1'b0, a, op);
            m_open[idx] = 1'b1;
            m_row[idx]  = row;
            m_act[idx]  = act_at;
            rw_at = act_at + T_RCD;
        end
        push(rw_at, 1'b0, (op == OP_WRITE) ? CMD_WR : CMD_RD, !OPEN, a, op);
        if (!OPEN)
            m_open[idx] = 1'b0;
        rsp_at = rw_at + ((op == OP_WRITE) ? T_CWL : T_CL) + T_BURST;
        push(rsp_at, 1'b1, CMD_NOP, 1'b0, a, op);
        rdy = OPEN ? rsp_at : rsp_at + T_RP;
        // Busy: valid held with changing garbage must be ignored.
        for (int k = 0; k < 4; k++) begin
            req.opcode = opcode_t'(2'($urandom_range(0, 2)));
            req.addr   = 33'({$urandom(), $urandom()});
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic finish_req(input int rdy);
        int n = 0;
        while (cyc < rdy - 1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_while_busy", req_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("ready_at_done", req_ready, 1'b1);
        chk("events_pending", q.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_cmd", cmd, CMD_NOP);
        chk("rst_cmd_ap", cmd_ap, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col}, 0);
    endtask

    initial begin
        int t, rdy;
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = '0;
            m_act[i]  = -1000;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_first_edge", req_ready, 1'b1);

        accept(OP_READ, mk(2'd0, 2'd0, 15'd0, 8'd0), t, rdy);
        finish_req(rdy);
        accept(OP_READ, mk(2'd0, 2'd0, 15'd0, 8'd4), t, rdy);
        finish_req(rdy);
        accept(OP_READ, mk(2'd0, 2'd1, 15'd0, 8'd2), t, rdy);
        finish_req(rdy);
        accept(OP_READ, mk(2'd0, 2'd1, 15'd9, 8'd1), t, rdy);
        finish_req(rdy);
        accept(OP_WRITE, mk(2'd1, 2'd2, 15'd3, 8'd5), t, rdy);
        finish_req(rdy);
        accept(OP_IFETCH, mk(2'd3, 2'd3, 15'h7fff, 8'hff), t, rdy);
        finish_req(rdy);
        accept(OP_WRITE, mk(2'd3, 2'd3, 15'h7fff, 8'h10), t, rdy);
        finish_req(rdy);

        // Reset mid-request after its ACT: no response, bank left closed.
        accept(OP_READ, mk(2'd2, 2'd1, 15'h1234, 8'd7), t, rdy);
        while (cyc < t + 10)
            @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        q.delete();
        for (int i = 0; i < 16; i++)
            m_open[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rerst", req_ready, 1'b1);
        accept(OP_READ, mk(2'd2, 2'd1, 15'h1234, 8'd7), t, rdy);
        finish_req(rdy);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
